// File: rtl/ysyx_22040365_ifu.sv
// rtl/ysyx_22040365_ifu.sv - instruction fetch unit: single-outstanding fetch FSM with redirect and stale-response drop
module ysyx_22040365_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] redirect_aligned;
    logic        unused_redirect_lsbs;

    assign redirect_aligned     = {redirect_pc[63:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign mem_req_valid = (state == S_REQ);
    assign mem_req_addr  = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= {RESET_PC[63:2], 2'b00};
            inst       <= 32'h0000_0013;
            inst_pc    <= 64'd0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        // An accepted request still owes a response that must be thrown away.
                        state <= mem_req_ready ? S_DROP : S_REQ;
                    end else if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_aligned;
                        state <= mem_rsp_valid ? S_REQ : S_DROP;
                    end else if (mem_rsp_valid) begin
                        inst       <= mem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc         <= redirect_aligned;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end else if (inst_ready) begin
                        pc         <= pc + 64'd4;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                    // The stale response retires the outstanding request even if a redirect lands with it.
                    if (mem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// tb/tb_ysyx_22040365_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22040365_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'd0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;

    logic        mem_req_valid, inst_valid;
    logic [63:0] mem_req_addr, inst_pc;
    logic [31:0] inst;

    logic        w_mem_req_valid, w_inst_valid;
    logic [63:0] w_mem_req_addr, w_inst_pc;
    logic [31:0] w_inst;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    ysyx_22040365_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ysyx_22040365_ifu #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(w_mem_req_valid), .mem_req_addr(w_mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic accept();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = data;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %h exp 0", inst_valid); end
        checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst got %h exp 00000013", inst); end
        checks++; if (inst_pc !== 64'd0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %h exp 1", mem_req_valid); end
        checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("FAIL reset_req_addr got %h exp 80000000", mem_req_addr); end
    endtask

    task automatic test_basic();
        do_reset();
        accept();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_req_valid got %h exp 0", mem_req_valid); end
        step();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_inst_valid got %h exp 0", inst_valid); end
        exp_q.push_back('{32'h0010_0093, 64'h8000_0000});
        respond(32'h0010_0093);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_inst_valid got %h exp 1", inst_valid); end
        e = exp_q.pop_front();
        checks++; if (inst !== e.inst) begin errors++; $display("FAIL basic_inst got %h exp %h", inst, e.inst); end
        checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL basic_inst_pc got %h exp %h", inst_pc, e.pc); end
        consume();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_after_consume_valid got %h exp 0", inst_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0004) begin
            errors++; $display("FAIL basic_next_addr got %h/%h exp 1/80000004", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        accept();
        step();
        exp_q.push_back('{32'h1234_5678, 64'h8000_0000});
        respond(32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            // A stray response during HOLD must not disturb the held instruction.
            mem_rsp_valid = (i == 2);
            mem_rsp_data = 32'hbad0_bad0;
            step();
            mem_rsp_valid = 1'b0;
            checks++; if (inst_valid !== 1'b1 || inst !== exp_q[0].inst || inst_pc !== exp_q[0].pc) begin
                errors++; $display("FAIL bp_hold_%0d got %h/%h/%h exp 1/%h/%h", i, inst_valid, inst, inst_pc, exp_q[0].inst, exp_q[0].pc); end
            checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_%0d got %h exp 0", i, mem_req_valid); end
        end
        e = exp_q.pop_front();
        checks++; if (inst !== e.inst || inst_pc !== e.pc) begin errors++; $display("FAIL bp_pop got %h/%h exp %h/%h", inst, inst_pc, e.inst, e.pc); end
        consume();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0004) begin
            errors++; $display("FAIL bp_next_addr got %h/%h exp 1/80000004", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        accept();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_req_valid got %h exp 0", mem_req_valid); end
        respond(32'hdead_beef);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_discard got %h exp 0", inst_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000) begin
            errors++; $display("FAIL rw_next_addr got %h/%h exp 1/80001000", mem_req_valid, mem_req_addr); end
        // Redirect together with the response: response discarded, straight back to REQ.
        accept();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2007;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h1111_1111;
        step();
        redirect_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_same_cycle_valid got %h exp 0", inst_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_2004) begin
            errors++; $display("FAIL rw_same_cycle_addr got %h/%h exp 1/80002004", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_req();
        do_reset();
        // Redirect while the request is stalled: stay in REQ at the new address.
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0010;
        step();
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010) begin
            errors++; $display("FAIL rr_stall_addr got %h/%h exp 1/80000010", mem_req_valid, mem_req_addr); end
        // Redirect on an accepted request: DROP, then a redirect inside DROP updates the pc.
        mem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0300;
        step();
        mem_req_ready = 1'b0;
        redirect_pc = 64'h8000_0400;
        step();
        redirect_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_drop_req_valid got %h exp 0", mem_req_valid); end
        respond(32'h2222_2222);
        checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0400) begin
            errors++; $display("FAIL rr_drop_exit got %h/%h/%h exp 0/1/80000400", inst_valid, mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0010;
        step();
        redirect_valid = 1'b0;
        accept();
        exp_q.push_back('{32'h0000_0067, 64'h8000_0010});
        respond(32'h0000_0067);
        e = exp_q.pop_front();
        checks++; if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
            errors++; $display("FAIL rh_inst got %h/%h/%h exp 1/%h/%h", inst_valid, inst, inst_pc, e.inst, e.pc); end
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        step();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_valid_drop got %h exp 0", inst_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0200) begin
            errors++; $display("FAIL rh_next_addr got %h/%h exp 1/80000200", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (w_mem_req_valid !== 1'b1 || w_mem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
                errors++; $display("FAIL wrap_stall_%0d got %h/%h exp 1/fffffffffffffffc", i, w_mem_req_valid, w_mem_req_addr); end
        end
        accept();
        step();
        respond(32'h0000_0073);
        checks++; if (w_inst_valid !== 1'b1 || w_inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC || w_inst !== 32'h0000_0073) begin
            errors++; $display("FAIL wrap_inst got %h/%h/%h exp 1/fffffffffffffffc/00000073", w_inst_valid, w_inst_pc, w_inst); end
        consume();
        checks++; if (w_mem_req_valid !== 1'b1 || w_mem_req_addr !== 64'd0) begin
            errors++; $display("FAIL wrap_next_addr got %h/%h exp 1/0", w_mem_req_valid, w_mem_req_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        accept();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmw_inst_valid got %h exp 0", inst_valid); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
            errors++; $display("FAIL rmw_req got %h/%h exp 1/80000000", mem_req_valid, mem_req_addr); end
        respond(32'h3333_3333);
        checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
            errors++; $display("FAIL rmw_stray_rsp got %h/%h exp 0/1", inst_valid, mem_req_valid); end
        checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL rmw_inst_nop got %h exp 00000013", inst); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pc_model;
        logic [31:0] data;
        int          lat;
        do_reset();
        pc_model = 64'h8000_0000;
        for (int n = 0; n < 6; n++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== pc_model) begin
                errors++; $display("FAIL b2b_addr_%0d got %h/%h exp 1/%h", n, mem_req_valid, mem_req_addr, pc_model); end
            lat = $urandom_range(0, 3);
            data = $urandom;
            if (n > 0) begin
                repeat ($urandom_range(0, 2)) step();
            end
            accept();
            repeat (lat) step();
            exp_q.push_back('{data, pc_model});
            respond(data);
            repeat ($urandom_range(0, 2)) step();
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL b2b_queue_empty_%0d got 0 exp 1", n);
            end else begin
                e = exp_q.pop_front();
                checks++; if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc) begin
                    errors++; $display("FAIL b2b_inst_%0d got %h/%h/%h exp 1/%h/%h", n, inst_valid, inst, inst_pc, e.inst, e.pc); end
            end
            consume();
            pc_model = pc_model + 64'd4;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_hold();
        test_wrap_stall();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040365_ifu.md
YSYX_22040365_IFU -- requirements
Module: ysyx_22040365_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 mem_req_valid  output  1  fetch request valid.
REQ-005 mem_req_addr  output  64  fetch address; always 4-byte aligned.
REQ-006 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 mem_rsp_valid  input  1  fetch data returned this cycle.
REQ-008 mem_rsp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  instruction available to the ID stage.
REQ-010 inst  output  32  instruction word to the ID stage.
REQ-011 inst_pc  output  64  PC of inst.
REQ-012 inst_ready  input  1  ID stage consumes inst this cycle.
REQ-013 redirect_valid  input  1  PC redirect from a branch, jump or trap.
REQ-014 redirect_pc  input  64  redirect target.

Function
REQ-015 The FSM SHALL have four states:
- REQ: issue a request.
- WAIT: await the response.
- HOLD: present the instruction.
- DROP: discard a stale response.
REQ-016 In REQ, mem_req_valid SHALL be 1 with mem_req_addr = pc; on mem_req_ready the FSM SHALL move to WAIT.
REQ-017 mem_req_valid SHALL be 0 in WAIT, HOLD and DROP.
REQ-018 While mem_req_valid=1 and mem_req_ready=0, mem_req_addr SHALL be held stable unless a redirect occurs.
REQ-019 In WAIT, on mem_rsp_valid the block SHALL register mem_rsp_data into inst and pc into inst_pc, then move to HOLD.
- inst_valid rises the cycle after mem_rsp_valid (one-cycle latency).
REQ-020 inst_valid SHALL be 1 exactly in HOLD; inst and inst_pc SHALL be held stable while inst_valid=1 and inst_ready=0.
REQ-021 In HOLD with inst_ready=1, pc SHALL become pc+4 (modulo 2^64, wraps to 0) and the FSM SHALL move to REQ.
REQ-022 mem_rsp_valid outside WAIT and DROP SHALL be ignored.
REQ-023 On redirect_valid=1, in any state, pc SHALL load {redirect_pc[63:2],2'b00} on the next edge.
REQ-024 Redirect next-state rules:
- from HOLD: go to REQ; inst_valid drops the next cycle. A redirect has priority over a simultaneous inst_ready, so pc+4 is not applied.
- from REQ with mem_req_ready=0: go to REQ.
- from REQ with mem_req_ready=1 (request already accepted): go to DROP.
- from WAIT with mem_rsp_valid=0: go to DROP.
- from WAIT with mem_rsp_valid=1: discard the response, go to REQ.
- from DROP: stay in DROP with the new pc.
REQ-025 In DROP, on mem_rsp_valid the response SHALL be discarded (inst_valid stays 0) and the FSM SHALL move to REQ.
REQ-026 Only one outstanding memory request SHALL exist at any time.

Reset
REQ-027 On rst_n=0 at a rising edge, the block SHALL set:
- state = REQ
- pc = RESET_PC
- inst = 32'h0000_0013 (nop)
- inst_pc = 0
- inst_valid = 0
REQ-028 The reset SHALL take effect from any state, including mid-request. A response arriving after reset while the FSM is in REQ is ignored per REQ-022.
REQ-029 In the first cycle after reset release, mem_req_valid SHALL be 1 with mem_req_addr = RESET_PC.

Verification
REQ-030 Basic fetch: reset release, mem_req_ready=1, response 2 cycles later with data 32'h00100093 -> inst_valid=1 the next cycle, inst=32'h00100093, inst_pc=64'h80000000; after inst_ready, next mem_req_addr=64'h80000004.
REQ-031 Back-pressure: hold inst_ready=0 for 5 cycles while in HOLD -> inst and inst_pc unchanged, mem_req_valid=0 throughout; inst_ready=1 -> REQ at 64'h80000004.
REQ-032 Redirect in WAIT: redirect_pc=64'h80001002 while awaiting response -> response with 32'hdeadbeef discarded (inst_valid stays 0); next mem_req_addr=64'h80001000.
REQ-033 Redirect and inst_ready together in HOLD at pc 64'h80000010, redirect_pc=64'h80000200 -> next mem_req_addr=64'h80000200, never 64'h80000014.
REQ-034 Wrap and stall: RESET_PC=64'hFFFFFFFF_FFFFFFFC with mem_req_ready=0 for 3 cycles -> address stable; after consume, next mem_req_addr=0.
REQ-035 Reset mid-WAIT: assert rst_n=0 for one cycle -> inst_valid=0; next request at RESET_PC; a stray mem_rsp_valid in REQ does not raise inst_valid.
